// File: rtl/crc_pkg.sv
// crc_pkg: register map, status bit positions, engine states and CRC defaults
package crc_pkg;
   localparam logic [7:0] ADDR_DATA   = 8'h00;
   localparam logic [7:0] ADDR_CTRL   = 8'h01;
   localparam logic [7:0] ADDR_STATUS = 8'h02;
   localparam logic [7:0] ADDR_RESULT = 8'h03;
   localparam logic [7:0] ADDR_INIT   = 8'h04;
   localparam logic [7:0] ADDR_XOROUT = 8'h05;
   localparam int STAT_BUSY  = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_LEVEL = 8;
   localparam logic [31:0] POLY_DEF   = 32'hEDB88320;
   localparam logic [31:0] INIT_DEF   = 32'hFFFFFFFF;
   localparam logic [31:0] XOROUT_DEF = 32'hFFFFFFFF;
   typedef enum logic {ST_IDLE, ST_RUN} eng_state_e;
endpackage

// File: rtl/crc_byte_step.sv
// crc_byte_step: one reflected CRC byte update, eight shift/xor iterations
module crc_byte_step import crc_pkg::*; #(
   parameter int          CRC_W = 32,
   parameter logic [31:0] POLY  = POLY_DEF
) (
   input  logic [CRC_W-1:0] crc_in,
   input  logic [7:0]       data,
   output logic [CRC_W-1:0] crc_out
);
   localparam logic [CRC_W-1:0] P = POLY[CRC_W-1:0];
   logic [CRC_W-1:0] c;
   always_comb begin
      c = crc_in ^ CRC_W'(data);
      for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ P : c >> 1;
      crc_out = c;
   end
endmodule

// File: rtl/avs_mm_crc_engine.sv
// avs_mm_crc_engine: Avalon-MM CRC slave with byte-enabled input FIFO and byte-serial engine
module avs_mm_crc_engine import crc_pkg::*; #(
   parameter int          CRC_W      = 32,
   parameter logic [31:0] POLY       = POLY_DEF,
   parameter logic [31:0] INIT_RST   = INIT_DEF,
   parameter logic [31:0] XOROUT_RST = XOROUT_DEF,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic [3:0]  avs_byteenable,
   output logic [31:0] avs_readdata,
   output logic        avs_readdatavalid,
   output logic        avs_waitrequest
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [31:0] fifo_data [FIFO_DEPTH];
   logic [3:0]  fifo_be [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, level;
   logic fifo_empty, fifo_full, busy, wr_ok, rd_ok, push, pop, clear;
   eng_state_e state;
   logic [31:0] word, init_r, xorout_r, status, rdata;
   logic [3:0] mask, low, mask_nx;
   logic [7:0] lane_byte;
   logic [CRC_W-1:0] crc, crc_nx;
   assign level = wr_ptr - rd_ptr;
   assign fifo_empty = level == '0;
   assign fifo_full = level == (AW+1)'(FIFO_DEPTH);
   assign busy = !fifo_empty || state == ST_RUN;
   assign avs_waitrequest = (avs_write && avs_address == ADDR_DATA && fifo_full) ||
                            (avs_read && avs_address == ADDR_RESULT && busy);
   assign wr_ok = avs_write && !avs_waitrequest;
   assign rd_ok = avs_read && !avs_waitrequest;
   assign push = wr_ok && avs_address == ADDR_DATA && |avs_byteenable;
   assign clear = wr_ok && avs_address == ADDR_CTRL && avs_writedata[0];
   // lowest enabled lane goes first; disabled lanes are never visited
   assign low = mask & (~mask + 4'd1);
   assign mask_nx = mask & ~low;
   assign lane_byte = mask[0] ? word[7:0] : mask[1] ? word[15:8] : mask[2] ? word[23:16] : word[31:24];
   assign pop = !fifo_empty && (state == ST_IDLE || mask_nx == '0);
   crc_byte_step #(.CRC_W(CRC_W), .POLY(POLY)) u_step (
      .crc_in  (crc),
      .data    (lane_byte),
      .crc_out (crc_nx)
   );
   always_comb begin
      status = '0;
      status[STAT_BUSY] = busy;
      status[STAT_FULL] = fifo_full;
      status[STAT_LEVEL +: 8] = 8'(level);
      rdata = avs_address == ADDR_STATUS ? status :
              avs_address == ADDR_RESULT ? 32'(crc ^ xorout_r[CRC_W-1:0]) :
              avs_address == ADDR_INIT   ? init_r :
              avs_address == ADDR_XOROUT ? xorout_r : '0;
   end
   always_ff @(posedge clk)
      if (push) begin
         fifo_data[wr_ptr[AW-1:0]] <= avs_writedata;
         fifo_be[wr_ptr[AW-1:0]] <= avs_byteenable;
      end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         state <= ST_IDLE;
         word <= '0;
         mask <= '0;
         crc <= INIT_RST[CRC_W-1:0];
         init_r <= INIT_RST;
         xorout_r <= XOROUT_RST;
         avs_readdata <= '0;
         avs_readdatavalid <= 1'b0;
      end else begin
         avs_readdatavalid <= rd_ok;
         if (rd_ok) avs_readdata <= rdata;
         if (wr_ok && avs_address == ADDR_INIT) init_r <= avs_writedata;
         if (wr_ok && avs_address == ADDR_XOROUT) xorout_r <= avs_writedata;
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            state <= ST_IDLE;
            mask <= '0;
            crc <= init_r[CRC_W-1:0];
         end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) begin
               rd_ptr <= rd_ptr + (AW+1)'(1);
               word <= fifo_data[rd_ptr[AW-1:0]];
            end
            if (state == ST_RUN) crc <= crc_nx;
            mask <= pop ? fifo_be[rd_ptr[AW-1:0]] : mask_nx;
            state <= (pop || mask_nx != '0) ? ST_RUN : ST_IDLE;
         end
      end
endmodule
